// File: rtl/mips_mc_controller.sv
// -----------------------------------------------------------------------------
// mips_mc_controller
//
// Main control FSM for a multi-cycle MIPS datapath. Sequences each instruction
// through FETCH / DECODE and an opcode-specific tail (LW, SW, R-type, BEQ,
// ADDI, J), driving datapath mux selects and write enables from the current
// state. Unsupported opcodes park the FSM in HALT with a sticky illegal flag
// until reset.
//
// Build option:
//   MIPS_MC_MEM_STALL_EN - when defined, FETCH, MEMRD and MEMWR wait for
//                          mem_ready=1; pc_en in FETCH and retire in MEMWR are
//                          qualified by mem_ready. When undefined, mem_ready
//                          is ignored and every memory state lasts one cycle.
//
// Ports:
//   clk        in   1  clock, all state changes on rising edge
//   rst        in   1  synchronous active-high reset
//   opcode     in   6  instr[31:26] from the instruction register
//   zero       in   1  ALU zero flag (gates pc_en in BRANCH)
//   mem_ready  in   1  memory access-complete strobe
//   iord, ir_write, mem_read, mem_write, reg_write, reg_dst, mem_to_reg,
//   alu_src_a  out  1  datapath mux selects / enables
//   alu_src_b  out  2  ALU B operand select
//   pc_src     out  2  next-PC select
//   alu_op     out  2  00 ADD, 01 SUB, 10 funct-decoded
//   pc_en      out  1  PC load enable
//   retire     out  1  one-cycle pulse when an instruction completes
//   illegal    out  1  sticky unsupported-opcode flag
//   state      out  4  current FSM state (debug)
// -----------------------------------------------------------------------------
module mips_mc_controller (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       iord,
  output logic       ir_write,
  output logic       mem_read,
  output logic       mem_write,
  output logic       reg_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] pc_src,
  output logic [1:0] alu_op,
  output logic       pc_en,
  output logic       retire,
  output logic       illegal,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_ADDIEX = 4'd9,
    S_ADDIWB = 4'd10,
    S_JUMP   = 4'd11,
    S_HALT   = 4'd12
  } state_t;

  typedef struct packed {
    logic       iord;
    logic       ir_write;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_src;
    logic [1:0] alu_op;
    logic       pc_en;
    logic       retire;
  } ctrl_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  state_t r_state;
  ctrl_t  r_ctrl;
  logic   r_illegal;
  state_t w_next_state;
  logic   w_mem_ok;

  // Moore output table; BRANCH pc_en is left 0 here because it comes from zero.
  function automatic ctrl_t decode_ctrl(input state_t s);
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH: begin
        c.mem_read  = 1'b1;
        c.ir_write  = 1'b1;
        c.alu_src_b = 2'b01;
        c.pc_en     = 1'b1;
      end
      S_DECODE: c.alu_src_b = 2'b11;
      S_MEMADR: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = 2'b10;
      end
      S_MEMRD: begin
        c.iord     = 1'b1;
        c.mem_read = 1'b1;
      end
      S_MEMWB: begin
        c.reg_write  = 1'b1;
        c.mem_to_reg = 1'b1;
        c.retire     = 1'b1;
      end
      S_MEMWR: begin
        c.iord      = 1'b1;
        c.mem_write = 1'b1;
        c.retire    = 1'b1;
      end
      S_EXEC: begin
        c.alu_src_a = 1'b1;
        c.alu_op    = 2'b10;
      end
      S_ALUWB: begin
        c.reg_write = 1'b1;
        c.reg_dst   = 1'b1;
        c.retire    = 1'b1;
      end
      S_BRANCH: begin
        c.alu_src_a = 1'b1;
        c.alu_op    = 2'b01;
        c.pc_src    = 2'b01;
        c.retire    = 1'b1;
      end
      S_ADDIEX: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = 2'b10;
      end
      S_ADDIWB: begin
        c.reg_write = 1'b1;
        c.retire    = 1'b1;
      end
      S_JUMP: begin
        c.pc_src = 2'b10;
        c.pc_en  = 1'b1;
        c.retire = 1'b1;
      end
      S_HALT:  c = '0;
      default: c = '0;
    endcase
    return c;
  endfunction

`ifdef MIPS_MC_MEM_STALL_EN
  assign w_mem_ok = mem_ready;
`else
  // Memory is assumed single-cycle; the strobe is deliberately unused.
  logic w_unused_mem_ready;
  assign w_unused_mem_ready = mem_ready;
  assign w_mem_ok           = 1'b1;
`endif

  // Next-state selection from current state, opcode and memory handshake.
  always_comb begin
    w_next_state = S_FETCH;
    case (r_state)
      S_FETCH:  w_next_state = w_mem_ok ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW: w_next_state = S_MEMADR;
          OP_RTYPE:     w_next_state = S_EXEC;
          OP_BEQ:       w_next_state = S_BRANCH;
          OP_ADDI:      w_next_state = S_ADDIEX;
          OP_J:         w_next_state = S_JUMP;
          default:      w_next_state = S_HALT;
        endcase
      end
      // Opcode is still held in the IR here, so it selects load vs. store.
      S_MEMADR: begin
        if (opcode == OP_SW) begin
          w_next_state = S_MEMWR;
        end else begin
          w_next_state = S_MEMRD;
        end
      end
      S_MEMRD:  w_next_state = w_mem_ok ? S_MEMWB : S_MEMRD;
      S_MEMWB:  w_next_state = S_FETCH;
      S_MEMWR:  w_next_state = w_mem_ok ? S_FETCH : S_MEMWR;
      S_EXEC:   w_next_state = S_ALUWB;
      S_ALUWB:  w_next_state = S_FETCH;
      S_BRANCH: w_next_state = S_FETCH;
      S_ADDIEX: w_next_state = S_ADDIWB;
      S_ADDIWB: w_next_state = S_FETCH;
      S_JUMP:   w_next_state = S_FETCH;
      S_HALT:   w_next_state = S_HALT;
      default:  w_next_state = S_FETCH;
    endcase
  end

  // State register with outputs pre-decoded from the next state, so each
  // output register holds exactly the Moore value of the state it accompanies.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_FETCH;
      r_ctrl    <= decode_ctrl(S_FETCH);
      r_illegal <= 1'b0;
    end else begin
      r_state   <= w_next_state;
      r_ctrl    <= decode_ctrl(w_next_state);
      r_illegal <= r_illegal |
                   ((r_state == S_DECODE) && (w_next_state == S_HALT));
    end
  end

  assign iord       = r_ctrl.iord;
  assign ir_write   = r_ctrl.ir_write;
  assign mem_read   = r_ctrl.mem_read;
  assign mem_write  = r_ctrl.mem_write;
  assign reg_write  = r_ctrl.reg_write;
  assign reg_dst    = r_ctrl.reg_dst;
  assign mem_to_reg = r_ctrl.mem_to_reg;
  assign alu_src_a  = r_ctrl.alu_src_a;
  assign alu_src_b  = r_ctrl.alu_src_b;
  assign pc_src     = r_ctrl.pc_src;
  assign alu_op     = r_ctrl.alu_op;
  assign illegal    = r_illegal;
  assign state      = r_state;

  // BRANCH takes the branch only when the ALU compare hit; FETCH only advances
  // the PC on the cycle memory actually delivers the instruction.
  assign pc_en  = (r_state == S_BRANCH) ? zero
                : (r_ctrl.pc_en & ((r_state != S_FETCH) | w_mem_ok));

  // A stalled store completes (and retires) only on its mem_ready cycle.
  assign retire = r_ctrl.retire & ((r_state != S_MEMWR) | w_mem_ok);

endmodule

// File: tb/tb_mips_mc_controller.sv
// -----------------------------------------------------------------------------
// tb_mips_mc_controller
//
// Directed self-checking bench for mips_mc_controller. Observed control
// vector packing (MSB..LSB):
//   iord ir_write mem_read mem_write reg_write reg_dst mem_to_reg alu_src_a
//   alu_src_b[1:0] pc_src[1:0] alu_op[1:0] pc_en retire
// With MIPS_MC_MEM_STALL_EN defined, a store-stall scenario is run instead of
// the single-cycle-memory scenarios.
// -----------------------------------------------------------------------------
module tb_mips_mc_controller;

  logic       clk;
  logic       rst;
  logic [5:0] opcode;
  logic       zero;
  logic       mem_ready;
  logic       iord, ir_write, mem_read, mem_write, reg_write, reg_dst;
  logic       mem_to_reg, alu_src_a;
  logic [1:0] alu_src_b, pc_src, alu_op;
  logic       pc_en, retire, illegal;
  logic [3:0] state;

  int n_tests = 0;
  int n_fail  = 0;

  // Hand-written expected control vectors per state.
  localparam logic [15:0] V_FETCH  = 16'b0_1_1_0_0_0_0_0_01_00_00_1_0;
  localparam logic [15:0] V_DECODE = 16'b0_0_0_0_0_0_0_0_11_00_00_0_0;
  localparam logic [15:0] V_MEMADR = 16'b0_0_0_0_0_0_0_1_10_00_00_0_0;
  localparam logic [15:0] V_MEMRD  = 16'b1_0_1_0_0_0_0_0_00_00_00_0_0;
  localparam logic [15:0] V_MEMWB  = 16'b0_0_0_0_1_0_1_0_00_00_00_0_1;
  localparam logic [15:0] V_MEMWR  = 16'b1_0_0_1_0_0_0_0_00_00_00_0_1;
  localparam logic [15:0] V_EXEC   = 16'b0_0_0_0_0_0_0_1_00_00_10_0_0;
  localparam logic [15:0] V_BR_Z1  = 16'b0_0_0_0_0_0_0_1_00_01_01_1_1;
  localparam logic [15:0] V_BR_Z0  = 16'b0_0_0_0_0_0_0_1_00_01_01_0_1;
  localparam logic [15:0] V_HALT   = 16'b0_0_0_0_0_0_0_0_00_00_00_0_0;

  logic [15:0] w_obs;
  assign w_obs = {iord, ir_write, mem_read, mem_write, reg_write, reg_dst,
                  mem_to_reg, alu_src_a, alu_src_b, pc_src, alu_op, pc_en, retire};

  mips_mc_controller dut (
    .clk        (clk),
    .rst        (rst),
    .opcode     (opcode),
    .zero       (zero),
    .mem_ready  (mem_ready),
    .iord       (iord),
    .ir_write   (ir_write),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .reg_write  (reg_write),
    .reg_dst    (reg_dst),
    .mem_to_reg (mem_to_reg),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .pc_src     (pc_src),
    .alu_op     (alu_op),
    .pc_en      (pc_en),
    .retire     (retire),
    .illegal    (illegal),
    .state      (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic st(input string tag, input logic [3:0] exp_state, input logic [15:0] exp_vec);
    chk({tag, "_state"}, {12'd0, state}, {12'd0, exp_state});
    chk({tag, "_ctrl"}, w_obs, exp_vec);
  endtask

  logic [5:0] prog [3];
  int         ret_cyc [$];
  int         idx;

  initial begin
    rst       = 1'b1;
    opcode    = 6'h00;
    zero      = 1'b0;
    mem_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    st("reset", 4'd0, V_FETCH);
    chk("reset_illegal", {15'd0, illegal}, 16'd0);

`ifdef MIPS_MC_MEM_STALL_EN
    // Store with stalls: FETCH waits, MEMWR waits three cycles.
    opcode = 6'h2B;
    chk("stall_fetch_pcen0", {15'd0, pc_en}, 16'd0);
    tick();
    st("stall_fetch_hold", 4'd0, {V_FETCH[15:2], 1'b0, 1'b0});
    mem_ready = 1'b1;
    #1;
    chk("stall_fetch_pcen1", {15'd0, pc_en}, 16'd1);
    tick();
    mem_ready = 1'b0;
    st("stall_sw_dec", 4'd1, V_DECODE);
    tick();
    st("stall_sw_adr", 4'd2, V_MEMADR);
    for (int i = 0; i < 3; i++) begin
      tick();
      st("stall_sw_wait", 4'd5, {V_MEMWR[15:1], 1'b0});
    end
    mem_ready = 1'b1;
    #1;
    st("stall_sw_ready", 4'd5, V_MEMWR);
    tick();
    chk("stall_sw_done_state", {12'd0, state}, 16'd0);
`else
    // LW: 0,1,2,3,4,0 with mem_ready held low (ignored).
    opcode = 6'h23;
    tick(); st("lw_dec", 4'd1, V_DECODE);
    tick(); st("lw_adr", 4'd2, V_MEMADR);
    tick(); st("lw_rd",  4'd3, V_MEMRD);
    tick(); st("lw_wb",  4'd4, V_MEMWB);
    tick(); st("lw_end", 4'd0, V_FETCH);

    // SW: 0,1,2,5,0.
    opcode = 6'h2B;
    tick(); st("sw_dec", 4'd1, V_DECODE);
    tick(); st("sw_adr", 4'd2, V_MEMADR);
    tick(); st("sw_wr",  4'd5, V_MEMWR);
    tick(); st("sw_end", 4'd0, V_FETCH);

    // BEQ taken, then zero drops mid-state: pc_en follows combinationally.
    opcode = 6'h04;
    zero   = 1'b1;
    tick(); st("beq1_dec", 4'd1, V_DECODE);
    tick(); st("beq1_br",  4'd8, V_BR_Z1);
    zero = 1'b0;
    #1;
    chk("beq_pcen_follows_zero", {15'd0, pc_en}, 16'd0);
    tick(); st("beq1_end", 4'd0, V_FETCH);

    // BEQ not taken.
    tick(); st("beq0_dec", 4'd1, V_DECODE);
    tick(); st("beq0_br",  4'd8, V_BR_Z0);
    tick(); st("beq0_end", 4'd0, V_FETCH);

    // Back-to-back R, ADDI, J: retire at cycles 4, 8, 11 from FETCH = cycle 1.
    prog[0] = 6'h00;
    prog[1] = 6'h08;
    prog[2] = 6'h02;
    idx = 0;
    for (int c = 1; c <= 11; c++) begin
      if (state == 4'd0 && idx < 3) begin
        opcode = prog[idx];
        idx++;
      end
      if (retire === 1'b1) ret_cyc.push_back(c);
      tick();
    end
    chk("stream_retire_count", ret_cyc.size(), 16'd3);
    if (ret_cyc.size() == 3) begin
      chk("stream_retire_r",    ret_cyc[0], 16'd4);
      chk("stream_retire_addi", ret_cyc[1], 16'd8);
      chk("stream_retire_j",    ret_cyc[2], 16'd11);
    end
    st("stream_end", 4'd0, V_FETCH);

    // Reset during EXEC: back to FETCH, no retire, no register write.
    opcode = 6'h00;
    tick(); st("rexec_dec", 4'd1, V_DECODE);
    tick(); st("rexec_exec", 4'd6, V_EXEC);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rexec_retire",    {15'd0, retire},    16'd0);
    chk("rexec_reg_write", {15'd0, reg_write}, 16'd0);
    st("rexec_after", 4'd0, V_FETCH);

    // Illegal opcode: HALT for 10 cycles regardless of zero/mem_ready, then reset.
    opcode = 6'h3F;
    tick(); st("halt_dec", 4'd1, V_DECODE);
    chk("halt_dec_illegal", {15'd0, illegal}, 16'd0);
    for (int i = 0; i < 10; i++) begin
      tick();
      st("halt_hold", 4'd12, V_HALT);
      chk("halt_illegal", {15'd0, illegal}, 16'd1);
      zero      = ~zero;
      mem_ready = ~mem_ready;
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    st("halt_reset", 4'd0, V_FETCH);
    chk("halt_reset_illegal", {15'd0, illegal}, 16'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mips_mc_controller.md
MIPS_MC_CONTROLLER -- requirements
Module: mips_mc_controller

Interface
REQ-001 The block SHALL have port clk, input, 1 bit: single clock; all state updates occur on its rising edge.
REQ-002 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-003 The block SHALL have port opcode, input, 6 bits: instr[31:26], sampled from the instruction register.
REQ-004 The block SHALL have port zero, input, 1 bit: ALU zero flag.
REQ-005 The block SHALL have port mem_ready, input, 1 bit: memory access-complete strobe.
REQ-006 The block SHALL have ports iord, ir_write, mem_read, mem_write, reg_write, reg_dst, mem_to_reg, alu_src_a, each output, 1 bit: datapath mux and enable controls.
REQ-007 The block SHALL have ports alu_src_b and pc_src, each output, 2 bits: mux selects.
REQ-008 The block SHALL have port alu_op, output, 2 bits: 00 = ADD, 01 = SUB, 10 = funct-decoded.
REQ-009 The block SHALL have port pc_en, output, 1 bit: PC load enable.
REQ-010 The block SHALL have port retire, output, 1 bit: one-cycle pulse when an instruction completes.
REQ-011 The block SHALL have port illegal, output, 1 bit: sticky unsupported-opcode flag.
REQ-012 The block SHALL have port state, output, 4 bits: current FSM state, for debug.

Function
REQ-013 The FSM SHALL use these states: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, ALUWB=7, BRANCH=8, ADDIEX=9, ADDIWB=10, JUMP=11, HALT=12; codes 13-15 SHALL go to FETCH.
REQ-014 FETCH outputs SHALL be: iord=0, mem_read=1, ir_write=1, alu_src_a=0, alu_src_b=01, alu_op=00, pc_src=00, pc_en=1.
REQ-015 FETCH SHALL go to DECODE.
REQ-016 DECODE outputs SHALL be: alu_src_a=0, alu_src_b=11, alu_op=00 (branch target precompute).
REQ-017 DECODE next state SHALL follow opcode:
- 0x23 (LW) or 0x2B (SW) -> MEMADR
- 0x00 (R-type) -> EXEC
- 0x04 (BEQ) -> BRANCH
- 0x08 (ADDI) -> ADDIEX
- 0x02 (J) -> JUMP
- any other opcode -> HALT
REQ-018 MEMADR outputs SHALL be alu_src_a=1, alu_src_b=10, alu_op=00; next state SHALL be MEMRD for LW and MEMWR for SW.
REQ-019 MEMRD outputs SHALL be iord=1, mem_read=1; next state SHALL be MEMWB.
REQ-020 MEMWB outputs SHALL be reg_write=1, reg_dst=0, mem_to_reg=1, retire=1; next state SHALL be FETCH.
REQ-021 MEMWR outputs SHALL be iord=1, mem_write=1, retire=1; next state SHALL be FETCH.
REQ-022 EXEC outputs SHALL be alu_src_a=1, alu_src_b=00, alu_op=10; next state SHALL be ALUWB.
REQ-023 ALUWB outputs SHALL be reg_write=1, reg_dst=1, mem_to_reg=0, retire=1; next state SHALL be FETCH.
REQ-024 BRANCH outputs SHALL be alu_src_a=1, alu_src_b=00, alu_op=01, pc_src=01, pc_en=zero, retire=1; next state SHALL be FETCH.
REQ-025 ADDIEX outputs SHALL be alu_src_a=1, alu_src_b=10, alu_op=00; next state SHALL be ADDIWB.
REQ-026 ADDIWB outputs SHALL be reg_write=1, reg_dst=0, mem_to_reg=0, retire=1; next state SHALL be FETCH.
REQ-027 JUMP outputs SHALL be pc_src=10, pc_en=1, retire=1; next state SHALL be FETCH.
REQ-028 HALT SHALL drive all enables to 0 and remain in HALT until reset.
REQ-029 illegal SHALL set to 1 on the DECODE->HALT transition and hold until reset.
REQ-030 Outputs SHALL be Moore (decoded from state only), except pc_en in BRANCH, which follows zero combinationally.
REQ-031 Any output not listed for a state SHALL be 0.
REQ-032 Latencies in cycles, FETCH through last state, SHALL be: LW 5, SW 4, R 4, ADDI 4, BEQ 3, J 3 (no-stall build).

Reset
REQ-033 When rst=1 at a clock edge, state SHALL become FETCH and illegal SHALL become 0, overriding any in-progress instruction or HALT.
REQ-034 While in FETCH after reset, outputs SHALL follow REQ-014; the block SHALL hold no other state.
REQ-035 An instruction interrupted by reset SHALL NOT assert retire.

Configuration
REQ-036 With macro MIPS_MC_MEM_STALL_EN defined, FETCH, MEMRD and MEMWR SHALL hold their state and outputs until a cycle with mem_ready=1.
REQ-037 In that build, pc_en in FETCH and retire in MEMWR SHALL assert only in the cycle where mem_ready=1.
REQ-038 Without the macro, mem_ready SHALL be ignored and every memory state SHALL last exactly 1 cycle.

Verification
REQ-039 Reset, then opcode=0x23 -> states 0,1,2,3,4,0; retire=1 only in state 4, with reg_write=1 and mem_to_reg=1.
REQ-040 opcode=0x04, zero=1 -> in BRANCH, pc_en=1 and pc_src=01; with zero=0 -> pc_en=0; retire=1 in both cases.
REQ-041 opcode=0x3F -> HALT, illegal=1, all enables 0 for 10 cycles; then rst=1 for 1 cycle -> state=0, illegal=0.
REQ-042 rst asserted in state EXEC -> next state=0, no retire, no reg_write pulse.
REQ-043 MIPS_MC_MEM_STALL_EN build: opcode=0x2B with mem_ready low 3 cycles in MEMWR -> mem_write held 4 cycles, retire only on the mem_ready cycle.
REQ-044 Back-to-back R, ADDI, J stream -> retire pulses at cycles 4, 8, 11 counted from the first FETCH (cycle 1).
